// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM line buffer: FSM state encoding,
// address/data widths and the longest burst the memory controller accepts.
package psram_pkg;

  localparam int unsigned ADDR_W    = 22;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned MAX_BURST = 128;

  typedef enum logic [2:0] {
    IDLE,
    FILL_REQ,
    FILL,
    WR_REQ,
    WR_WAIT
  } state_t;

endpackage

// File: rtl/psram_line_ram.sv
// One line of 2^LINE_LOG2 words: single write port, registered read port.
// Contents are deliberately not reset.
module psram_line_ram
  import psram_pkg::*;
#(
  parameter int unsigned LINE_LOG2 = 3
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [LINE_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 re,
  input  logic [LINE_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]    q
);

  logic [DATA_W-1:0] mem [1 << LINE_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/psram_line_buffer.sv
// Single-line read buffer in front of the PSRAM burst controller; writes pass through.
// Define PSRAM_LINE_BUFFER_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module psram_line_buffer
  import psram_pkg::*;
#(
  parameter int unsigned LINE_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] d,
  input  logic              we,
  input  logic              rd,
  input  logic              inv,
  output logic [DATA_W-1:0] spo,
  output logic              ready,
  output logic [ADDR_W-1:0] mc_a,
  output logic [DATA_W-1:0] mc_d,
  output logic              mc_we,
  output logic              mc_rd,
  output logic              mc_burst_en,
  output logic [7:0]        mc_burst_length,
  input  logic [DATA_W-1:0] mc_spo,
  input  logic              mc_ready
`ifdef PSRAM_LINE_BUFFER_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int unsigned LINE_WORDS = 1 << LINE_LOG2;
  localparam int unsigned TAG_W      = ADDR_W - LINE_LOG2;

  state_t               state, state_next;
  logic                 valid;
  logic [TAG_W-1:0]     tag_r, fill_tag;
  logic [LINE_LOG2-1:0] off_l, count;
  logic [DATA_W-1:0]    spo_r, ram_q, ram_wdata;
  logic                 spo_src;
  logic                 ram_we, ram_re;
  logic [LINE_LOG2-1:0] ram_waddr;

  logic [LINE_LOG2-1:0] offset;
  logic [TAG_W-1:0]     tag;
  logic                 hit, rd_acc;

  assign offset = a[LINE_LOG2-1:0];
  assign tag    = a[ADDR_W-1:LINE_LOG2];
  assign hit    = valid && (tag == tag_r);
  assign rd_acc = (state == IDLE) && !inv && !we && rd;

  // Hit data comes straight from the RAM read register; fill data from spo_r.
  assign spo = spo_src ? ram_q : spo_r;

  psram_line_ram #(.LINE_LOG2(LINE_LOG2)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (offset),
    .q     (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (!inv) begin
          if (we)            state_next = WR_REQ;
          else if (rd && !hit) state_next = FILL_REQ;
        end
      end
      FILL_REQ: state_next = FILL;
      FILL:     if (mc_ready && count == '1) state_next = IDLE;
      WR_REQ:   state_next = WR_WAIT;
      WR_WAIT:  if (mc_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    mc_rd     = (state == FILL_REQ);
    mc_we     = (state == WR_REQ);
    ram_re    = rd_acc && hit;
    ram_we    = 1'b0;
    ram_waddr = offset;
    ram_wdata = d;
    if (state == IDLE && !inv && we && hit) begin
      ram_we = 1'b1;
    end else if (state == FILL && mc_ready) begin
      ram_we    = 1'b1;
      ram_waddr = count;
      ram_wdata = mc_spo;
    end
  end

  // Request fields are loaded on the accepting edge so they are already
  // stable during the one-cycle mc_rd/mc_we pulse, then held until the next request.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid           <= 1'b0;
      tag_r           <= '0;
      fill_tag        <= '0;
      off_l           <= '0;
      count           <= '0;
      spo_r           <= '0;
      spo_src         <= 1'b0;
      ready           <= 1'b0;
      mc_a            <= '0;
      mc_d            <= '0;
      mc_burst_en     <= 1'b0;
      mc_burst_length <= '0;
    end else begin
      ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (inv) begin
            valid <= 1'b0;
          end else if (we) begin
            mc_a            <= a;
            mc_d            <= d;
            mc_burst_en     <= 1'b0;
            mc_burst_length <= 8'd1;
          end else if (rd) begin
            if (hit) begin
              ready   <= 1'b1;
              spo_src <= 1'b1;
            end else begin
              valid           <= 1'b0;
              off_l           <= offset;
              fill_tag        <= tag;
              mc_a            <= {tag, {LINE_LOG2{1'b0}}};
              mc_burst_en     <= 1'b1;
              mc_burst_length <= 8'(LINE_WORDS);
            end
          end
        end
        FILL_REQ: count <= '0;
        FILL: begin
          if (mc_ready) begin
            if (count == off_l) begin
              spo_r   <= mc_spo;
              spo_src <= 1'b0;
            end
            if (count == '1) begin
              valid <= 1'b1;
              tag_r <= fill_tag;
              ready <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        WR_WAIT: if (mc_ready) ready <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PSRAM_LINE_BUFFER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rd_acc) begin
      if (hit && hit_cnt != '1)        hit_cnt  <= hit_cnt + 1'b1;
      else if (!hit && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_psram_line_buffer.sv
// Directed bench for psram_line_buffer (LINE_LOG2=3); the bench plays the
// memory controller, returning hand-chosen burst data on mc_ready pulses.
module tb_psram_line_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [21:0] a = '0;
  logic [31:0] d = '0;
  logic        we = 1'b0, rd = 1'b0, inv = 1'b0;
  logic [31:0] spo;
  logic        ready;
  logic [21:0] mc_a;
  logic [31:0] mc_d;
  logic        mc_we, mc_rd, mc_burst_en;
  logic [7:0]  mc_burst_length;
  logic [31:0] mc_spo = '0;
  logic        mc_ready = 1'b0;
`ifdef PSRAM_LINE_BUFFER_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int ready_cnt = 0;
  int rdreq_cnt = 0;
  int r0, q0;

  psram_line_buffer #(.LINE_LOG2(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .a               (a),
    .d               (d),
    .we              (we),
    .rd              (rd),
    .inv             (inv),
    .spo             (spo),
    .ready           (ready),
    .mc_a            (mc_a),
    .mc_d            (mc_d),
    .mc_we           (mc_we),
    .mc_rd           (mc_rd),
    .mc_burst_en     (mc_burst_en),
    .mc_burst_length (mc_burst_length),
    .mc_spo          (mc_spo),
    .mc_ready        (mc_ready)
`ifdef PSRAM_LINE_BUFFER_STATS_EN
    ,
    .hit_cnt         (hit_cnt),
    .miss_cnt        (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, clear of both clock edges.
  always @(posedge clk) begin
    #2;
    if (ready) ready_cnt++;
    if (mc_rd) rdreq_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_rd(input logic [21:0] addr);
    a  = addr;
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  task automatic do_wr(input logic [21:0] addr, input logic [31:0] data);
    a  = addr;
    d  = data;
    we = 1'b1;
    step();
    we = 1'b0;
    check("wr_mc_we", {31'b0, mc_we}, 32'd1);
    check("wr_mc_a", {10'b0, mc_a}, {10'b0, addr});
    check("wr_mc_d", mc_d, data);
    check("wr_burst_en", {31'b0, mc_burst_en}, 32'd0);
    check("wr_burst_len", {24'b0, mc_burst_length}, 32'd1);
    step();
    mc_ready = 1'b1;
    step();
    mc_ready = 1'b0;
    check("wr_ready", {31'b0, ready}, 32'd1);
  endtask

  // Entered on the cycle mc_rd is expected high; answers with 8 mc_ready pulses.
  task automatic serve_fill(input logic [21:0] base, input logic [31:0] d0,
                            input logic [31:0] exp_spo, input bit inject);
    check("fill_mc_rd", {31'b0, mc_rd}, 32'd1);
    check("fill_mc_a", {10'b0, mc_a}, {10'b0, base});
    check("fill_burst_en", {31'b0, mc_burst_en}, 32'd1);
    check("fill_burst_len", {24'b0, mc_burst_length}, 32'd8);
    for (int i = 0; i < 8; i++) begin
      step();
      mc_ready = 1'b1;
      mc_spo   = d0 + 32'(i);
      if (inject && i == 3) begin
        a  = 22'h000030;
        rd = 1'b1;
      end else begin
        rd = 1'b0;
      end
    end
    step();
    mc_ready = 1'b0;
    rd = 1'b0;
    check("fill_ready", {31'b0, ready}, 32'd1);
    check("fill_spo", spo, exp_spo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(); step(); step();
    rst = 1'b0;
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_spo", spo, 32'd0);
    check("rst_mc_rd", {31'b0, mc_rd}, 32'd0);
    check("rst_mc_we", {31'b0, mc_we}, 32'd0);
    check("rst_mc_a", {10'b0, mc_a}, 32'd0);
    check("rst_mc_d", mc_d, 32'd0);
    check("rst_burst_en", {31'b0, mc_burst_en}, 32'd0);
    check("rst_burst_len", {24'b0, mc_burst_length}, 32'd0);

    // Cold miss, then hits including back-to-back acceptance.
    do_rd(22'h000013);
    serve_fill(22'h000010, 32'hA0, 32'hA3, 1'b0);
    q0 = rdreq_cnt;
    do_rd(22'h000016);
    check("hit_ready", {31'b0, ready}, 32'd1);
    check("hit_spo", spo, 32'hA6);
    do_rd(22'h000017);
    check("b2b_ready", {31'b0, ready}, 32'd1);
    check("b2b_spo", spo, 32'hA7);
    check("hit_no_refill", 32'(rdreq_cnt - q0), 32'd0);

    // Write hit updates the line; write miss leaves it alone.
    do_wr(22'h000011, 32'hDEADBEEF);
    do_rd(22'h000011);
    check("wrhit_rd_spo", spo, 32'hDEADBEEF);
    do_wr(22'h000045, 32'h12345678);
    do_rd(22'h000015);
    check("wrmiss_rd_spo", spo, 32'hA5);
    check("wr_no_refill", 32'(rdreq_cnt - q0), 32'd0);

    // Invalidate forces a refetch; inv itself completes nothing.
    r0 = ready_cnt;
    inv = 1'b1;
    step();
    inv = 1'b0;
    step();
    check("inv_no_ready", 32'(ready_cnt - r0), 32'd0);
    do_rd(22'h000012);
    serve_fill(22'h000010, 32'hB0, 32'hB2, 1'b0);

    // Tag change: new line, old line no longer hits.
    do_rd(22'h000020);
    serve_fill(22'h000020, 32'hC0, 32'hC0, 1'b0);
    do_rd(22'h000012);
    serve_fill(22'h000010, 32'hD0, 32'hD2, 1'b0);

    // A rd strobe mid-burst is ignored.
    r0 = ready_cnt;
    q0 = rdreq_cnt;
    do_rd(22'h000024);
    serve_fill(22'h000020, 32'hE0, 32'hE4, 1'b1);
    step(); step(); step();
    check("inject_one_ready", 32'(ready_cnt - r0), 32'd1);
    check("inject_one_burst", 32'(rdreq_cnt - q0), 32'd1);

    // Reset while idle with a valid line clears valid.
    rst = 1'b1;
    step();
    rst = 1'b0;
    do_rd(22'h000024);
    serve_fill(22'h000020, 32'h50, 32'h54, 1'b0);

    // Reset on the 4th mc_ready of a fill.
    do_rd(22'h000010);
    check("abort_mc_rd", {31'b0, mc_rd}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      mc_ready = 1'b1;
      mc_spo   = 32'hF0 + 32'(i);
      if (i == 3) rst = 1'b1;
    end
    step();
    rst = 1'b0;
    mc_ready = 1'b0;
    check("abort_ready", {31'b0, ready}, 32'd0);
    check("abort_spo", spo, 32'd0);
    check("abort_mc_rd_low", {31'b0, mc_rd}, 32'd0);
    check("abort_mc_a", {10'b0, mc_a}, 32'd0);
    check("abort_burst_en", {31'b0, mc_burst_en}, 32'd0);
    check("abort_burst_len", {24'b0, mc_burst_length}, 32'd0);
    step();
    check("abort_stays_idle", {31'b0, mc_rd}, 32'd0);
    do_rd(22'h000010);
    serve_fill(22'h000010, 32'h60, 32'h60, 1'b0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
